// File: rtl/data_mem_bridge.sv
// ----------------------------------------------------------------------------
// data_mem_bridge
//
// Converts the single-cycle core's load/store request into a registered
// request/acknowledge bus transaction that tolerates any number of wait
// states. The core is stalled while the transaction is outstanding and is
// released for exactly one commit cycle (DONE). A hung transaction is
// aborted after TIMEOUT cycles in REQ and flagged with a one-cycle busErr.
//
// Parameters
//   TIMEOUT    maximum REQ cycles before abort, legal range 1..65535
//
// Ports
//   clk        core clock (single domain)
//   reset      synchronous, active-high reset
//   memRead    core load request, level, held while stall=1
//   memWrite   core store request, level, held while stall=1 (wins over load)
//   address    byte address from the ALU
//   storeData  lane-aligned store word
//   byteEn     store byte strobes, bit i = byte lane i
//   readData   registered read word to the load unit
//   stall      combinational stall to the core (PC / register write freeze)
//   busErr     one-cycle pulse in the DONE cycle of a timed-out access
//   busReq     registered bus request, high for the whole REQ state
//   busWe      registered direction, 1 = write
//   busAddr    registered word address {address[31:2],2'b00}
//   busWdata   registered copy of storeData
//   busBe      registered strobes, byteEn for writes, 4'hF for reads
//   busRdata   read data from memory, valid with busAck
//   busAck     single-cycle transaction-complete pulse
// ----------------------------------------------------------------------------
module data_mem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic [3:0]  byteEn,
    output logic [31:0] readData,
    output logic        stall,
    output logic        busErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic [31:0] busRdata,
    input  logic        busAck
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wait counter value seen in the last permitted REQ cycle.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic [15:0] cnt_q,      cnt_d;
    logic        busReq_q,   busReq_d;
    logic        busWe_q,    busWe_d;
    logic [31:0] busAddr_q,  busAddr_d;
    logic [31:0] busWdata_q, busWdata_d;
    logic [3:0]  busBe_q,    busBe_d;
    logic [31:0] readData_q, readData_d;
    logic        busErr_q,   busErr_d;

    logic        access;

    // Byte offset is irrelevant on a word-wide bus.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^address[1:0];

    assign access = memRead | memWrite;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busWdata_q <= '0;
            busBe_q    <= '0;
            readData_q <= '0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busReq_q   <= busReq_d;
            busWe_q    <= busWe_d;
            busAddr_q  <= busAddr_d;
            busWdata_q <= busWdata_d;
            busBe_q    <= busBe_d;
            readData_q <= readData_d;
            busErr_q   <= busErr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic. busReq/busErr are computed as
    // next-state values so they appear on the bus as clean register outputs
    // aligned with the REQ and first DONE cycle respectively.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busReq_d   = busReq_q;
        busWe_d    = busWe_q;
        busAddr_d  = busAddr_q;
        busWdata_d = busWdata_q;
        busBe_d    = busBe_q;
        readData_d = readData_q;
        busErr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                busReq_d = 1'b0;
                if (access) begin
                    // Store wins when both requests are raised together.
                    busWe_d    = memWrite;
                    busAddr_d  = {address[31:2], 2'b00};
                    busWdata_d = storeData;
                    busBe_d    = memWrite ? byteEn : 4'hF;
                    cnt_d      = '0;
                    busReq_d   = 1'b1;
                    state_d    = REQ;
                end
            end

            REQ: begin
                // An ack in the final permitted cycle beats the timeout.
                if (busAck) begin
                    if (!busWe_q) begin
                        readData_d = busRdata;
                    end
                    busReq_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!busWe_q) begin
                        readData_d = '0;
                    end
                    busErr_d = 1'b1;
                    busReq_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DONE: begin
                // Always pass through IDLE so a held or new request is only
                // picked up one cycle after the core commits.
                busReq_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                busReq_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall    = access && (state_q != DONE);
    assign busReq   = busReq_q;
    assign busWe    = busWe_q;
    assign busAddr  = busAddr_q;
    assign busWdata = busWdata_q;
    assign busBe    = busBe_q;
    assign readData = readData_q;
    assign busErr   = busErr_q;

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_req_only_in_req : assert property (
        @(posedge clk) disable iff (reset) busReq_q == (state_q == REQ));

    a_err_only_in_done : assert property (
        @(posedge clk) disable iff (reset) busErr_q |-> (state_q == DONE));

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] storeData = '0;
    logic [3:0]  byteEn = '0;
    logic [31:0] readData;
    logic        stall;
    logic        busErr;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic [31:0] busRdata = '0;
    logic        busAck = 1'b0;

    always #5 clk = ~clk;

    data_mem_bridge #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .memRead  (memRead),
        .memWrite (memWrite),
        .address  (address),
        .storeData(storeData),
        .byteEn   (byteEn),
        .readData (readData),
        .stall    (stall),
        .busErr   (busErr),
        .busReq   (busReq),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWdata (busWdata),
        .busBe    (busBe),
        .busRdata (busRdata),
        .busAck   (busAck)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = '0;

    // One complete core memory instruction. Starts at the next rising edge
    // (IDLE cycle) and returns at the falling edge of the DONE cycle.
    // ack_at = REQ cycle number carrying busAck, 0 = never ack.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [31:0] rdata,
                             input int ack_at, input bit mutate,
                             input bit ack_in_done);
        exp_t        e;
        int          reqc;
        bit          done;
        logic [31:0] prev_rd;
        prev_rd = exp_rdata;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; address = addr;
        storeData = wdata; byteEn = be; busAck = 1'b0;
        e.we     = wr;
        e.addr   = {addr[31:2], 2'b00};
        e.wdata  = wdata;
        e.be     = wr ? be : 4'hF;
        e.err    = (ack_at == 0);
        e.cycles = (ack_at == 0) ? int'(TO) : ack_at;
        e.rdata  = wr ? exp_rdata : ((ack_at == 0) ? 32'h0 : rdata);
        exp_rdata = e.rdata;
        sb.push_back(e);

        @(negedge clk);
        n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL idle_stall: got %b want 1", stall); end
        n_vec++; if (busReq !== 1'b0) begin n_bad++; $display("FAIL idle_busReq: got %b want 0", busReq); end
        n_vec++; if (busErr !== 1'b0) begin n_bad++; $display("FAIL idle_busErr: got %b want 0", busErr); end
        n_vec++; if (readData !== prev_rd) begin n_bad++; $display("FAIL idle_readData: got %h want %h", readData, prev_rd); end

        reqc = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #1;
            if (busReq !== 1'b1) begin
                done = 1;
            end else begin
                reqc++;
                busAck = (ack_at == reqc);
                busRdata = busAck ? rdata : $urandom;
                if (mutate) begin
                    address = $urandom; storeData = $urandom; byteEn = 4'($urandom);
                end
                @(negedge clk);
                n_vec++; if (busWe !== sb[0].we) begin n_bad++; $display("FAIL req_busWe: got %b want %b", busWe, sb[0].we); end
                n_vec++; if (busAddr !== sb[0].addr) begin n_bad++; $display("FAIL req_busAddr: got %h want %h", busAddr, sb[0].addr); end
                n_vec++; if (busWdata !== sb[0].wdata) begin n_bad++; $display("FAIL req_busWdata: got %h want %h", busWdata, sb[0].wdata); end
                n_vec++; if (busBe !== sb[0].be) begin n_bad++; $display("FAIL req_busBe: got %h want %h", busBe, sb[0].be); end
                n_vec++; if (stall !== 1'b1) begin n_bad++; $display("FAIL req_stall: got %b want 1", stall); end
                n_vec++; if (busErr !== 1'b0) begin n_bad++; $display("FAIL req_busErr: got %b want 0", busErr); end
            end
        end
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL txn_bound: busReq still %b after %0d cycles, want DONE", busReq, reqc);
            busAck = 1'b0;
            void'(sb.pop_front());
            return;
        end

        // Now in DONE, optionally throw a stray ack at it.
        busAck = ack_in_done;
        busRdata = $urandom;
        @(negedge clk);
        e = sb.pop_front();
        n_vec++; if (reqc !== e.cycles) begin n_bad++; $display("FAIL req_cycles: got %0d want %0d", reqc, e.cycles); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL done_stall: got %b want 0", stall); end
        n_vec++; if (busReq !== 1'b0) begin n_bad++; $display("FAIL done_busReq: got %b want 0", busReq); end
        n_vec++; if (busErr !== e.err) begin n_bad++; $display("FAIL done_busErr: got %b want %b", busErr, e.err); end
        n_vec++; if (readData !== e.rdata) begin n_bad++; $display("FAIL done_readData: got %h want %h", readData, e.rdata); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (busReq !== 1'b0) begin n_bad++; $display("FAIL rst_busReq: got %b want 0", busReq); end
        n_vec++; if (readData !== 32'h0) begin n_bad++; $display("FAIL rst_readData: got %h want 0", readData); end
        n_vec++; if (busAddr !== 32'h0) begin n_bad++; $display("FAIL rst_busAddr: got %h want 0", busAddr); end
        n_vec++; if (busBe !== 4'h0) begin n_bad++; $display("FAIL rst_busBe: got %h want 0", busBe); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_zero_wait_load();
        do_access(1'b1, 1'b0, 32'h0000_0106, 32'h0, 4'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    endtask

    task automatic test_store_waits();
        // Core inputs are scrambled during REQ to confirm the latched copy holds.
        do_access(1'b0, 1'b1, 32'h0000_2003, 32'h1234_0000, 4'b1100, 32'h0, 4, 1'b1, 1'b0);
    endtask

    task automatic test_idle_ack(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            memRead = 1'b0; memWrite = 1'b0;
            busAck = (i % 2 == 0);
            busRdata = $urandom;
            @(negedge clk);
            n_vec++; if (busReq !== 1'b0) begin n_bad++; $display("FAIL stray_busReq: got %b want 0", busReq); end
            n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stray_stall: got %b want 0", stall); end
            n_vec++; if (busErr !== 1'b0) begin n_bad++; $display("FAIL stray_busErr: got %b want 0", busErr); end
            n_vec++; if (readData !== exp_rdata) begin n_bad++; $display("FAIL stray_readData: got %h want %h", readData, exp_rdata); end
        end
        busAck = 1'b0;
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'hBAD0_BAD0, 0, 1'b0, 1'b0);
        test_idle_ack(2);
    endtask

    task automatic test_ack_at_limit();
        do_access(1'b1, 1'b0, 32'h0000_0405, 32'h0, 4'h0, 32'hA5A5_5A5A, int'(TO), 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_access(1'b1, 1'b1, 32'h0000_0508, 32'hDEAD_BEEF, 4'b0011, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h1111_2222, 2, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_1004, 32'h5566_7788, 4'b0101, 32'h0, 1, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 32'h0000_100A, 32'h0, 4'h0, 32'h3333_4444, 3, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        memRead = 1'b1; memWrite = 1'b0; address = 32'h0000_0ABC; busAck = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (busReq !== 1'b1) begin n_bad++; $display("FAIL mid_busReq_pre: got %b want 1", busReq); end
        reset = 1'b1;
        memRead = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (busReq !== 1'b0) begin n_bad++; $display("FAIL mid_busReq: got %b want 0", busReq); end
        n_vec++; if (busWe !== 1'b0) begin n_bad++; $display("FAIL mid_busWe: got %b want 0", busWe); end
        n_vec++; if (busAddr !== 32'h0) begin n_bad++; $display("FAIL mid_busAddr: got %h want 0", busAddr); end
        n_vec++; if (busWdata !== 32'h0) begin n_bad++; $display("FAIL mid_busWdata: got %h want 0", busWdata); end
        n_vec++; if (busBe !== 4'h0) begin n_bad++; $display("FAIL mid_busBe: got %h want 0", busBe); end
        n_vec++; if (readData !== 32'h0) begin n_bad++; $display("FAIL mid_readData: got %h want 0", readData); end
        n_vec++; if (busErr !== 1'b0) begin n_bad++; $display("FAIL mid_busErr: got %b want 0", busErr); end
        n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall: got %b want 0", stall); end
        reset = 1'b0;
        exp_rdata = 32'h0;
        do_access(1'b1, 1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 32'h7E57_0001, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_waits();
        test_timeout();
        test_ack_at_limit();
        test_simultaneous();
        test_idle_ack(3);
        test_back_to_back();
        test_reset_mid();
        test_idle_ack(1);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
